axi3_lp_controller: RTL and testbench

AXI3_LP_CONTROLLER -- requirements
Module: axi3_lp_controller

---
 rtl/axi3_lp_controller.sv | 167 ++++++++++++++++
 tb/tb_axi3_lp_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_lp_controller.sv
// AXI3 low-power handshake controller: tracks outstanding transfers, runs an idle timer
// and sequences the CSYSREQ/CSYSACK/CSYSACTIVE exchange with the peripheral.
//
// state  | meaning
// RUN    | normal traffic, watching for sleep_req or idle timeout
// DRAIN  | new addresses blocked, waiting for outstanding transfers to finish
// REQ    | CSYSREQ low, waiting for the peripheral to acknowledge
// LOWPWR | peripheral accepted, bus in low-power state
// EXIT   | CSYSREQ high again, waiting for CSYSACK to return high
module axi3_lp_controller #(
  parameter int IDLE_CYCLES = 64,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 AWVALID,
  input  logic                 AWREADY,
  input  logic                 ARVALID,
  input  logic                 ARREADY,
  input  logic                 WVALID,
  input  logic                 BVALID,
  input  logic                 BREADY,
  input  logic                 RVALID,
  input  logic                 RREADY,
  input  logic                 RLAST,
  input  logic                 sleep_req,
  input  logic                 auto_en,
  output logic                 CSYSREQ,
  input  logic                 CSYSACK,
  input  logic                 CSYSACTIVE,
  output logic                 block_new,
  output logic                 lp_active,
  output logic                 denied,
  output logic [CNT_WIDTH-1:0] wr_out,
  output logic [CNT_WIDTH-1:0] rd_out
);

  typedef enum logic [2:0] {RUN, DRAIN, REQ, LOWPWR, EXIT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [15:0]          IDLE_MAX = 16'(IDLE_CYCLES);

  state_t               state;
  logic [15:0]          idle_cnt;
  logic                 rearm_wait;
  logic [CNT_WIDTH-1:0] wr_nxt;
  logic [CNT_WIDTH-1:0] rd_nxt;
  logic                 wr_inc, wr_dec, rd_inc, rd_dec;
  logic                 cnt_sat;
  logic                 bus_busy;
  logic                 idle_hit;
  logic                 run_enter;
  logic                 sleep_go;

  assign wr_inc = AWVALID & AWREADY;
  assign wr_dec = BVALID & BREADY;
  assign rd_inc = ARVALID & ARREADY;
  assign rd_dec = RVALID & RREADY & RLAST;

  always_comb begin
    wr_nxt = wr_out;
    if (wr_inc && !wr_dec && (wr_out != CNT_MAX))
      wr_nxt = wr_out + 1'b1;
    else if (wr_dec && !wr_inc && (wr_out != '0))
      wr_nxt = wr_out - 1'b1;
  end

  always_comb begin
    rd_nxt = rd_out;
    if (rd_inc && !rd_dec && (rd_out != CNT_MAX))
      rd_nxt = rd_out + 1'b1;
    else if (rd_dec && !rd_inc && (rd_out != '0))
      rd_nxt = rd_out - 1'b1;
  end

  // Saturation uses next-cycle counts so block_new lines up with the registered counters.
  assign cnt_sat   = (wr_nxt == CNT_MAX) || (rd_nxt == CNT_MAX);
  assign bus_busy  = AWVALID | ARVALID | WVALID | BVALID | RVALID |
                     (wr_out != '0) | (rd_out != '0);
  assign idle_hit  = (idle_cnt == IDLE_MAX);
  assign run_enter = (state == EXIT) && CSYSACK;
  assign sleep_go  = (sleep_req && !rearm_wait) || (auto_en && idle_hit);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_out <= '0;
      rd_out <= '0;
    end else begin
      wr_out <= wr_nxt;
      rd_out <= rd_nxt;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn)
      idle_cnt <= '0;
    else if (bus_busy || run_enter)
      idle_cnt <= '0;
    else if (!idle_hit)
      idle_cnt <= idle_cnt + 16'd1;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state      <= RUN;
      CSYSREQ    <= 1'b1;
      block_new  <= 1'b0;
      lp_active  <= 1'b0;
      denied     <= 1'b0;
      rearm_wait <= 1'b0;
    end else begin
      denied <= 1'b0;
      if (!sleep_req)
        rearm_wait <= 1'b0;
      case (state)
        RUN: begin
          if (sleep_go) begin
            state     <= DRAIN;
            block_new <= 1'b1;
          end else begin
            block_new <= cnt_sat;
          end
        end
        DRAIN: begin
          if ((wr_out == '0) && (rd_out == '0) && !AWVALID && !ARVALID) begin
            state   <= REQ;
            CSYSREQ <= 1'b0;
          end
        end
        REQ: begin
          if (!CSYSACK) begin
            if (CSYSACTIVE) begin
              // Denied: a still-high sleep_req must drop once before it can retrigger.
              state      <= EXIT;
              CSYSREQ    <= 1'b1;
              denied     <= 1'b1;
              rearm_wait <= sleep_req;
            end else begin
              state     <= LOWPWR;
              lp_active <= 1'b1;
            end
          end
        end
        LOWPWR: begin
          if (!sleep_req || CSYSACTIVE) begin
            state     <= EXIT;
            CSYSREQ   <= 1'b1;
            lp_active <= 1'b0;
          end
        end
        EXIT: begin
          if (CSYSACK) begin
            state     <= RUN;
            block_new <= cnt_sat;
          end
        end
        default: begin
          state     <= RUN;
          CSYSREQ   <= 1'b1;
          block_new <= 1'b0;
          lp_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi3_lp_controller.sv
// Bench for axi3_lp_controller: directed low-power scenarios plus random traffic,
// two instances (4-bit and 2-bit counters) checked against a cycle-level reference model.
module tb_axi3_lp_controller;

  localparam int IDLE = 8;

  logic ACLK, ARESETn;
  logic AWVALID, AWREADY, ARVALID, ARREADY, WVALID, BVALID, BREADY, RVALID, RREADY, RLAST;
  logic sleep_req, auto_en, CSYSACK, CSYSACTIVE;
  logic CSYSREQ, block_new, lp_active, denied;
  logic [3:0] wr_out, rd_out;
  logic csysreq_s, block_new_s, lp_active_s, denied_s;
  logic [1:0] wr_out_s, rd_out_s;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int wr;
    int rd;
    int timer;
    int phase;   // 0 run, 1 drain, 2 req, 3 low power, 4 exit
    bit rearm;
    bit csysreq;
    bit block;
    bit lp;
    bit denied;
  } mdl_t;

  mdl_t m0, m1;

  axi3_lp_controller #(.IDLE_CYCLES(IDLE), .CNT_WIDTH(4)) u_dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .WVALID(WVALID), .BVALID(BVALID), .BREADY(BREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .sleep_req(sleep_req), .auto_en(auto_en),
    .CSYSREQ(CSYSREQ), .CSYSACK(CSYSACK), .CSYSACTIVE(CSYSACTIVE),
    .block_new(block_new), .lp_active(lp_active), .denied(denied),
    .wr_out(wr_out), .rd_out(rd_out)
  );

  axi3_lp_controller #(.IDLE_CYCLES(IDLE), .CNT_WIDTH(2)) u_sat (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .WVALID(WVALID), .BVALID(BVALID), .BREADY(BREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .sleep_req(sleep_req), .auto_en(auto_en),
    .CSYSREQ(csysreq_s), .CSYSACK(CSYSACK), .CSYSACTIVE(CSYSACTIVE),
    .block_new(block_new_s), .lp_active(lp_active_s), .denied(denied_s),
    .wr_out(wr_out_s), .rd_out(rd_out_s)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(int v, int hi);
    if (v > hi) return hi;
    if (v < 0) return 0;
    return v;
  endfunction

  // One clock of the controller's rules, applied to the inputs present at this edge.
  function automatic mdl_t mnext(mdl_t m, int maxv);
    mdl_t n;
    bit busy;
    n = m;
    if (!ARESETn) begin
      n.wr = 0; n.rd = 0; n.timer = 0; n.phase = 0; n.rearm = 0;
      n.csysreq = 1; n.block = 0; n.lp = 0; n.denied = 0;
      return n;
    end
    n.wr = clamp(m.wr + int'(AWVALID && AWREADY) - int'(BVALID && BREADY), maxv);
    n.rd = clamp(m.rd + int'(ARVALID && ARREADY) - int'(RVALID && RREADY && RLAST), maxv);
    busy = AWVALID || ARVALID || WVALID || BVALID || RVALID || (m.wr != 0) || (m.rd != 0);
    n.denied = 0;
    case (m.phase)
      0: if ((sleep_req && !m.rearm) || (auto_en && m.timer == IDLE)) n.phase = 1;
      1: if (m.wr == 0 && m.rd == 0 && !AWVALID && !ARVALID) n.phase = 2;
      2: if (!CSYSACK) begin
           if (CSYSACTIVE) begin n.phase = 4; n.denied = 1; end
           else n.phase = 3;
         end
      3: if (!sleep_req || CSYSACTIVE) n.phase = 4;
      default: if (CSYSACK) n.phase = 0;
    endcase
    if (busy || (m.phase == 4 && CSYSACK)) n.timer = 0;
    else if (m.timer < IDLE) n.timer = m.timer + 1;
    if (n.denied) n.rearm = sleep_req;
    else if (!sleep_req) n.rearm = 0;
    n.csysreq = !(n.phase == 2 || n.phase == 3);
    n.lp      = (n.phase == 3);
    n.block   = (n.phase != 0) || (n.wr == maxv) || (n.rd == maxv);
    return n;
  endfunction

  task automatic compare_all();
    check("wr_out", 32'(wr_out), 32'(m0.wr));
    check("rd_out", 32'(rd_out), 32'(m0.rd));
    check("csysreq", 32'(CSYSREQ), 32'(m0.csysreq));
    check("block_new", 32'(block_new), 32'(m0.block));
    check("lp_active", 32'(lp_active), 32'(m0.lp));
    check("denied", 32'(denied), 32'(m0.denied));
    check("sat_wr_out", 32'(wr_out_s), 32'(m1.wr));
    check("sat_rd_out", 32'(rd_out_s), 32'(m1.rd));
    check("sat_csysreq", 32'(csysreq_s), 32'(m1.csysreq));
    check("sat_block_new", 32'(block_new_s), 32'(m1.block));
    check("sat_lp_active", 32'(lp_active_s), 32'(m1.lp));
    check("sat_denied", 32'(denied_s), 32'(m1.denied));
  endtask

  task automatic tick();
    @(posedge ACLK);
    m0 = mnext(m0, 15);
    m1 = mnext(m1, 3);
    @(negedge ACLK);
    compare_all();
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
  endtask

  task automatic bus_quiet();
    AWVALID = 0; AWREADY = 0; ARVALID = 0; ARREADY = 0; WVALID = 0;
    BVALID = 0; BREADY = 0; RVALID = 0; RREADY = 0; RLAST = 0;
  endtask

  initial begin
    bit quiet;
    ARESETn = 1'b0;
    bus_quiet();
    sleep_req = 0; auto_en = 0; CSYSACK = 1; CSYSACTIVE = 1;
    m0 = '{default: 0};
    m1 = '{default: 0};
    @(negedge ACLK);
    tick();
    tick();
    check("rst_csysreq", 32'(CSYSREQ), 32'd1);
    check("rst_block", 32'(block_new), 32'd0);
    check("rst_wr", 32'(wr_out), 32'd0);
    ARESETn = 1'b1;

    // Write counter: three AWs, AW+B hold, then B beats back down.
    AWVALID = 1; AWREADY = 1;
    for (int i = 1; i <= 3; i++) begin tick(); check("s1_aw", 32'(wr_out), 32'(i)); end
    BVALID = 1; BREADY = 1;
    tick(); check("s1_aw_b", 32'(wr_out), 32'd3);
    AWVALID = 0; AWREADY = 0;
    for (int i = 2; i >= 0; i--) begin tick(); check("s1_b", 32'(wr_out), 32'(i)); end
    bus_quiet();

    // Software entry with reads outstanding, drain, request, accept.
    ARVALID = 1; ARREADY = 1;
    tick(); tick();
    ARVALID = 0; ARREADY = 0;
    check("s2_rd", 32'(rd_out), 32'd2);
    sleep_req = 1;
    tick(); check("s2_block", 32'(block_new), 32'd1);
    check("s2_req_hi", 32'(CSYSREQ), 32'd1);
    RVALID = 1; RREADY = 1; RLAST = 1;
    tick(); tick();
    check("s2_rd0", 32'(rd_out), 32'd0);
    check("s2_still_drain", 32'(CSYSREQ), 32'd1);
    bus_quiet();
    tick(); check("s2_req_lo", 32'(CSYSREQ), 32'd0);
    CSYSACK = 0; CSYSACTIVE = 0;
    tick(); check("s2_lp", 32'(lp_active), 32'd1);

    // Peripheral-initiated wake.
    CSYSACTIVE = 1;
    tick(); check("s5_exit_req", 32'(CSYSREQ), 32'd1);
    check("s5_exit_lp", 32'(lp_active), 32'd0);
    sleep_req = 0; CSYSACK = 1;
    tick(); check("s5_run_block", 32'(block_new), 32'd0);

    // Denial and rearm.
    sleep_req = 1;
    tick(); tick(); check("s3_req_lo", 32'(CSYSREQ), 32'd0);
    CSYSACK = 0;
    tick(); check("s3_denied", 32'(denied), 32'd1);
    check("s3_req_hi", 32'(CSYSREQ), 32'd1);
    tick(); check("s3_denied_end", 32'(denied), 32'd0);
    CSYSACK = 1;
    tick(); check("s3_run", 32'(block_new), 32'd0);
    for (int i = 0; i < 3; i++) begin tick(); check("s3_hold", 32'(block_new), 32'd0); end
    sleep_req = 0;
    tick(); check("s3_low", 32'(block_new), 32'd0);
    sleep_req = 1;
    tick(); check("s3_retrigger", 32'(block_new), 32'd1);
    sleep_req = 0;
    do_reset();

    // Idle-timer entry and restart.
    auto_en = 1;
    do_reset();
    for (int i = 1; i <= IDLE; i++) begin tick(); check("s4_idle", 32'(block_new), 32'd0); end
    tick(); check("s4_entry", 32'(block_new), 32'd1);
    do_reset();
    for (int i = 1; i <= 13; i++) begin
      RVALID = (i == 5);
      tick(); check("s4_restart", 32'(block_new), 32'd0);
    end
    RVALID = 0;
    tick(); check("s4_entry2", 32'(block_new), 32'd1);
    auto_en = 0;
    do_reset();

    // 2-bit counter saturation, then reset out of low power.
    ARVALID = 1; ARREADY = 1;
    for (int i = 1; i <= 4; i++) begin
      tick(); check("s6_rd_sat", 32'(rd_out_s), 32'((i > 3) ? 3 : i));
    end
    check("s6_block_sat", 32'(block_new_s), 32'd1);
    check("s6_rd_wide", 32'(rd_out), 32'd4);
    bus_quiet();
    do_reset();
    sleep_req = 1;
    tick(); tick();
    CSYSACK = 0; CSYSACTIVE = 0;
    tick(); check("s6_lp", 32'(lp_active), 32'd1);
    ARESETn = 0;
    tick();
    check("s6_rst_req", 32'(CSYSREQ), 32'd1);
    check("s6_rst_lp", 32'(lp_active), 32'd0);
    check("s6_rst_block", 32'(block_new), 32'd0);
    ARESETn = 1; sleep_req = 0; CSYSACK = 1; CSYSACTIVE = 1;

    for (int i = 0; i < 3000; i++) begin
      quiet = ((i / 64) % 2) == 1;
      ARESETn = ($urandom_range(0, 199) != 0);
      if (quiet) bus_quiet();
      else begin
        AWVALID = ($urandom_range(0, 3) == 0); AWREADY = $urandom_range(0, 1) == 1;
        ARVALID = ($urandom_range(0, 3) == 0); ARREADY = $urandom_range(0, 1) == 1;
        WVALID  = ($urandom_range(0, 3) == 0);
        BVALID  = ($urandom_range(0, 3) == 0); BREADY  = $urandom_range(0, 1) == 1;
        RVALID  = ($urandom_range(0, 3) == 0); RREADY  = $urandom_range(0, 1) == 1;
        RLAST   = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 15) == 0) sleep_req = !sleep_req;
      if ($urandom_range(0, 39) == 0) auto_en = !auto_en;
      if ($urandom_range(0, 5) == 0) CSYSACK = !CSYSACK;
      if ($urandom_range(0, 7) == 0) CSYSACTIVE = !CSYSACTIVE;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
